// File: rtl/pipe_control.sv
// pipe_control: instruction decode, ID/EX/MEM/WB control pipeline, forwarding and hazard unit.
// Optional macro PIPE_CONTROL_FWD_EN: forwarding with load-use stalls only; undefined: stall on any RAW hazard.
module pipe_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic        zeroE,
    output logic        regWrite,
    output logic        mem2Reg,
    output logic        memWrite,
    output logic        regDst,
    output logic        aluSrcB,
    output logic [2:0]  aluControl,
    output logic        pcSrc,
    output logic [1:0]  fad,
    output logic [1:0]  fbd,
    output logic        flush,
    output logic        stall
);
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       reg_dst;
        logic       alu_src_b;
        logic [2:0] alu_control;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] rd_d;

    assign opcode = instrD[31:26];
    assign rs_d   = instrD[25:21];
    assign rt_d   = instrD[20:16];
    assign rd_d   = instrD[15:11];
    assign funct  = instrD[5:0];

    ctrl_t      ctrl_d;
    ctrl_t      ctrl_e;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] rd_e;
    logic [4:0] wr_e;
    logic       reg_write_m;
    logic       mem_to_reg_m;
    logic       mem_write_m;
    logic [4:0] wr_m;
    logic       reg_write_w;
    logic       mem_to_reg_w;
    logic [4:0] wr_w;
    logic       stall_raw;

    // NOTE: the bundle is cleared before the case so every path assigns it and no latch is inferred.
    always_comb begin
        ctrl_d = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  ctrl_d.alu_control = 3'b010;
                    FN_SUB:  ctrl_d.alu_control = 3'b110;
                    FN_AND:  ctrl_d.alu_control = 3'b000;
                    FN_OR:   ctrl_d.alu_control = 3'b001;
                    FN_SLT:  ctrl_d.alu_control = 3'b111;
                    default: ctrl_d = '0;
                endcase
            end
            OP_LW: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.mem_to_reg  = 1'b1;
                ctrl_d.alu_src_b   = 1'b1;
                ctrl_d.alu_control = 3'b010;
            end
            OP_SW: begin
                ctrl_d.mem_write   = 1'b1;
                ctrl_d.alu_src_b   = 1'b1;
                ctrl_d.alu_control = 3'b010;
            end
            OP_BEQ: begin
                ctrl_d.branch      = 1'b1;
                ctrl_d.alu_control = 3'b110;
            end
            OP_ADDI: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src_b   = 1'b1;
                ctrl_d.alu_control = 3'b010;
            end
            default: ctrl_d = '0;
        endcase
    end

    assign wr_e = ctrl_e.reg_dst ? rd_e : rt_e;

    // NOTE: non-blocking assignments let every stage capture the previous stage's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_e       <= '0;
            rs_e         <= '0;
            rt_e         <= '0;
            rd_e         <= '0;
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            mem_write_m  <= 1'b0;
            wr_m         <= '0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            wr_w         <= '0;
        end else begin
            if (stall || flush) begin
                ctrl_e <= '0;
                rs_e   <= '0;
                rt_e   <= '0;
                rd_e   <= '0;
            end else begin
                ctrl_e <= ctrl_d;
                rs_e   <= rs_d;
                rt_e   <= rt_d;
                rd_e   <= rd_d;
            end
            reg_write_m  <= ctrl_e.reg_write;
            mem_to_reg_m <= ctrl_e.mem_to_reg;
            mem_write_m  <= ctrl_e.mem_write;
            wr_m         <= wr_e;
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
            wr_w         <= wr_m;
        end
    end

`ifdef PIPE_CONTROL_FWD_EN
    logic unused_bits;
    assign unused_bits = ^instrD[10:6];

    // MEM result is newer than WB, so it takes priority.
    always_comb begin
        fad = 2'b00;
        fbd = 2'b00;
        if (reg_write_m && wr_m != 5'd0 && wr_m == rs_e)      fad = 2'b10;
        else if (reg_write_w && wr_w != 5'd0 && wr_w == rs_e) fad = 2'b01;
        if (reg_write_m && wr_m != 5'd0 && wr_m == rt_e)      fbd = 2'b10;
        else if (reg_write_w && wr_w != 5'd0 && wr_w == rt_e) fbd = 2'b01;
    end

    assign stall_raw = ctrl_e.mem_to_reg && (rt_e != 5'd0) && (rt_e == rs_d || rt_e == rt_d);
`else
    logic unused_bits;
    logic haz_rs;
    logic haz_rt;
    assign unused_bits = ^{instrD[10:6], rs_e, wr_w};

    // Without forwarding, wait until the producer reaches WB (write-first register file).
    assign haz_rs = (rs_d != 5'd0) &&
                    ((ctrl_e.reg_write && wr_e == rs_d) || (reg_write_m && wr_m == rs_d));
    assign haz_rt = (rt_d != 5'd0) &&
                    ((ctrl_e.reg_write && wr_e == rt_d) || (reg_write_m && wr_m == rt_d));
    assign stall_raw = haz_rs || haz_rt;
    assign fad = 2'b00;
    assign fbd = 2'b00;
`endif

    assign pcSrc      = ctrl_e.branch & zeroE;
    assign flush      = pcSrc;
    assign stall      = stall_raw & ~flush;
    assign regDst     = ctrl_e.reg_dst;
    assign aluSrcB    = ctrl_e.alu_src_b;
    assign aluControl = ctrl_e.alu_control;
    assign memWrite   = mem_write_m;
    assign regWrite   = reg_write_w;
    assign mem2Reg    = mem_to_reg_w;

endmodule

// File: tb/tb_pipe_control.sv
// Directed self-checking bench for pipe_control; covers both settings of PIPE_CONTROL_FWD_EN.
module tb_pipe_control;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrD;
    logic        zeroE;
    logic        regWrite;
    logic        mem2Reg;
    logic        memWrite;
    logic        regDst;
    logic        aluSrcB;
    logic [2:0]  aluControl;
    logic        pcSrc;
    logic [1:0]  fad;
    logic [1:0]  fbd;
    logic        flush;
    logic        stall;
    logic [14:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_control dut (
        .clk(clk), .rst(rst), .instrD(instrD), .zeroE(zeroE),
        .regWrite(regWrite), .mem2Reg(mem2Reg), .memWrite(memWrite),
        .regDst(regDst), .aluSrcB(aluSrcB), .aluControl(aluControl),
        .pcSrc(pcSrc), .fad(fad), .fbd(fbd), .flush(flush), .stall(stall)
    );

    always #5 clk = ~clk;

    assign outs = {regWrite, mem2Reg, memWrite, regDst, aluSrcB, aluControl,
                   pcSrc, fad, fbd, flush, stall};

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] ins);
        instrD = ins;
        #1;
    endtask

    task automatic drain();
        set_instr(32'h0);
        repeat (3) tick();
    endtask

    logic [31:0] NOP, ADD3, SUB4, LW8, LW5, ADD6, BEQ, ADDI10, ADDI0, ADD7, SW;
    logic [31:0] t_instr [9];
    logic [4:0]  t_ex    [9];
    logic        t_mw    [9];
    logic [1:0]  t_wb    [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        NOP    = 32'h0;
        ADD3   = rtype(6'b100000, 5'd1, 5'd2, 5'd3);
        SUB4   = rtype(6'b100010, 5'd3, 5'd3, 5'd4);
        LW8    = itype(6'b100011, 5'd0, 5'd8, 16'd4);
        LW5    = itype(6'b100011, 5'd0, 5'd5, 16'd0);
        ADD6   = rtype(6'b100000, 5'd5, 5'd5, 5'd6);
        BEQ    = itype(6'b000100, 5'd1, 5'd2, 16'd3);
        ADDI10 = itype(6'b001000, 5'd0, 5'd10, 16'd1);
        ADDI0  = itype(6'b001000, 5'd0, 5'd0, 16'd5);
        ADD7   = rtype(6'b100000, 5'd0, 5'd0, 5'd7);
        SW     = itype(6'b101011, 5'd1, 5'd2, 16'd0);

        // {regDst, aluSrcB, aluControl}, memWrite, {regWrite, mem2Reg}
        t_instr[0] = rtype(6'b100010, 5'd1, 5'd2, 5'd3); t_ex[0] = 5'b10110; t_mw[0] = 0; t_wb[0] = 2'b10;
        t_instr[1] = rtype(6'b100100, 5'd1, 5'd2, 5'd3); t_ex[1] = 5'b10000; t_mw[1] = 0; t_wb[1] = 2'b10;
        t_instr[2] = rtype(6'b100101, 5'd1, 5'd2, 5'd3); t_ex[2] = 5'b10001; t_mw[2] = 0; t_wb[2] = 2'b10;
        t_instr[3] = rtype(6'b101010, 5'd1, 5'd2, 5'd3); t_ex[3] = 5'b10111; t_mw[3] = 0; t_wb[3] = 2'b10;
        t_instr[4] = rtype(6'b100111, 5'd1, 5'd2, 5'd3); t_ex[4] = 5'b00000; t_mw[4] = 0; t_wb[4] = 2'b00;
        t_instr[5] = SW;                                 t_ex[5] = 5'b01010; t_mw[5] = 1; t_wb[5] = 2'b00;
        t_instr[6] = BEQ;                                t_ex[6] = 5'b00110; t_mw[6] = 0; t_wb[6] = 2'b00;
        t_instr[7] = itype(6'b001000, 5'd1, 5'd9, 16'd7); t_ex[7] = 5'b01010; t_mw[7] = 0; t_wb[7] = 2'b10;
        t_instr[8] = itype(6'b000010, 5'd1, 5'd2, 16'd7); t_ex[8] = 5'b00000; t_mw[8] = 0; t_wb[8] = 2'b00;

        // Reset held two cycles with an add waiting in ID.
        rst = 1'b1; zeroE = 1'b0; instrD = ADD3;
        tick(); tick();
        check("reset_all_zero", outs, 0);
        rst = 1'b0;
        #1;
        check("release_no_wb", regWrite, 0);
        tick(); set_instr(NOP);
        check("add_ex", {regDst, aluSrcB, aluControl}, 5'b10010);
        check("add_ex_no_wb", regWrite, 0);
        tick();
        check("add_mem_no_wb", regWrite, 0);
        tick();
        check("add_wb", {regWrite, mem2Reg}, 2'b10);
        tick();
        check("add_retired", regWrite, 0);

        // lw $8,4($0) through the pipe.
        set_instr(LW8); tick(); set_instr(NOP);
        check("lw_ex", {regDst, aluSrcB, aluControl}, 5'b01010);
        tick();
        check("lw_mem", {memWrite, regWrite}, 0);
        tick();
        check("lw_wb", {regWrite, mem2Reg}, 2'b11);
        drain();

        // add $3,$1,$2 ; sub $4,$3,$3
        set_instr(ADD3); tick(); set_instr(SUB4);
`ifdef PIPE_CONTROL_FWD_EN
        check("fwd_no_stall", stall, 0);
        tick(); set_instr(NOP);
        check("fwd_mem", {fad, fbd}, 4'b1010);
        drain();
        set_instr(ADD3); tick(); set_instr(NOP); tick(); set_instr(SUB4); tick(); set_instr(NOP);
        check("fwd_wb", {fad, fbd}, 4'b0101);
`else
        check("raw_stall_1", stall, 1);
        tick();
        check("raw_stall_2", stall, 1);
        check("raw_bubble", {regDst, aluControl}, 0);
        tick();
        check("raw_release", stall, 0);
        tick(); set_instr(NOP);
        check("raw_sub_ex", {fad, fbd, aluControl}, 7'b0000110);
`endif
        drain();

        // lw $5,0($0) ; add $6,$5,$5
        set_instr(LW5); tick(); set_instr(ADD6);
        check("lu_stall", stall, 1);
        tick();
        check("lu_bubble", {regDst, aluControl}, 0);
`ifdef PIPE_CONTROL_FWD_EN
        check("lu_stall_once", stall, 0);
        tick(); set_instr(NOP);
        check("lu_fwd_wb", {fad, fbd}, 4'b0101);
`else
        check("lu_stall_mem", stall, 1);
        tick();
        check("lu_release", stall, 0);
        tick(); set_instr(NOP);
        check("lu_add_ex", {regDst, aluControl, fad, fbd}, 8'b1_010_0000);
`endif
        drain();

        // Taken branch flushes the wrong-path addi.
        set_instr(BEQ); tick(); zeroE = 1'b1; set_instr(ADDI10);
        check("br_taken", {pcSrc, flush, stall}, 3'b110);
        tick(); zeroE = 1'b0; set_instr(NOP);
        check("br_flushed_ex", {regDst, aluSrcB, aluControl, pcSrc}, 0);
        tick();
        check("br_flushed_mem", memWrite, 0);
        drain();

        // Not-taken branch lets the next instruction through.
        set_instr(BEQ); tick(); set_instr(ADDI10);
        check("br_not_taken", {pcSrc, flush}, 0);
        tick(); set_instr(NOP);
        check("br_fallthrough_ex", {aluSrcB, aluControl}, 4'b1010);
        drain();

        // Register 0 never forwards or stalls.
        set_instr(ADDI0); tick(); set_instr(ADD7);
        check("zero_no_stall", stall, 0);
        tick(); set_instr(NOP);
        check("zero_no_fwd", {fad, fbd, stall}, 0);
        drain();

        // Reset mid-flight discards lw (MEM) and sw (EX).
        set_instr(LW8); tick(); set_instr(SW); tick(); set_instr(NOP);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_clear", outs, 0);
        tick();
        check("midreset_no_write", {regWrite, memWrite}, 0);
        drain();

        // Decode table across remaining opcodes and functs.
        for (int i = 0; i < 9; i++) begin
            set_instr(t_instr[i]); tick(); set_instr(NOP);
            check($sformatf("dec%0d_ex", i), {regDst, aluSrcB, aluControl}, t_ex[i]);
            tick();
            check($sformatf("dec%0d_mem", i), memWrite, t_mw[i]);
            tick();
            check($sformatf("dec%0d_wb", i), {regWrite, mem2Reg}, t_wb[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined control and hazard unit for the 32-bit five-stage processor. It decodes the instruction in ID, carries the control bundle through its own ID/EX, EX/MEM and MEM/WB registers, and drives the data path's stage-aligned control inputs. It also generates the forwarding selects, the load-use stall and the branch flush. It sits directly upstream of `dataPath` and is the sole source of every control input that `dataPath` consumes.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  synchronous reset, active-high
- `instrD`  in  32  instruction word in ID (from IF/ID register)
- `zeroE`  in  1  ALU zero flag of the instruction in EX
- `regWrite`  out  1  WB-stage register-file write enable
- `mem2Reg`  out  1  WB-stage: 1 = write data from memory, 0 = from ALU
- `memWrite`  out  1  MEM-stage data-memory write enable
- `regDst`  out  1  EX-stage: 1 = destination rd, 0 = destination rt
- `aluSrcB`  out  1  EX-stage: 1 = immediate, 0 = register B
- `aluControl`  out  3  EX-stage ALU op
- `pcSrc`  out  1  branch taken, resolved in EX
- `fad`  out  2  EX operand-A forward select
- `fbd`  out  2  EX operand-B forward select
- `flush`  out  1  clear IF/ID in `dataPath`
- `stall`  out  1  hold PC and IF/ID in `dataPath`

## Operation
- Decode (combinational, ID):
  - R-type `000000`:
    - regWrite=1, regDst=1.
    - ALU op by funct: add `100000`→`010`, sub `100010`→`110`, and `100100`→`000`, or `100101`→`001`, slt `101010`→`111`.
    - Any other funct: full nop.
  - lw `100011`: regWrite, mem2Reg, aluSrcB, aluControl `010`.
  - sw `101011`: memWrite, aluSrcB, aluControl `010`.
  - beq `000100`: branch, aluControl `110`.
  - addi `001000`: regWrite, aluSrcB, aluControl `010`.
  - Any other opcode: all-zero bundle (nop).
- Destination register:
  - Selected in EX as rd when regDst=1, else rt.
  - Carried with the bundle into MEM and WB as `wrM` and `wrW`.
  - rs and rt are also carried into EX as `rsE` and `rtE`.
- Forwarding (EX), encoding `00` = register file, `10` = MEM ALU result, `01` = WB result:
  - `fad=10` if regWriteM and wrM≠0 and wrM==rsE.
  - Else `fad=01` if regWriteW and wrW≠0 and wrW==rsE.
  - Else `fad=00`.
  - `fbd` uses the same rules with rtE. MEM has priority over WB.
- Load-use stall:
  - Condition: `stall` = mem2RegE and rtE≠0 and (rtE==rsD or rtE==rtD).
  - On the edge following a stall, ID/EX loads an all-zero bundle (bubble).
- Branch:
  - `pcSrc` = branchE & zeroE; `flush` = pcSrc.
  - On flush, ID/EX loads a bubble. `dataPath` clears IF/ID.
- Priority: stall and flush are mutually exclusive by construction (a lw and a beq cannot both occupy EX). If both are ever asserted, flush wins and `stall` is forced to 0.
- Register 0 never triggers forwarding or stall.

## Timing
- An instruction decoded in ID at cycle n drives:
  - EX outputs (regDst, aluSrcB, aluControl, fad, fbd, pcSrc) in cycle n+1.
  - memWrite in cycle n+2.
  - regWrite and mem2Reg in cycle n+3.
- `fad`, `fbd`, `stall`, `pcSrc` and `flush` are combinational from registered state plus `instrD`/`zeroE`, and valid within the same cycle.
- Reset:
  - While `rst` is high at an edge, all three pipeline registers load bubbles.
  - After that edge every output is 0: regWrite, mem2Reg, memWrite, regDst, aluSrcB, pcSrc, flush and stall are 0; aluControl, fad and fbd are `000`/`00`.
- Reset asserted mid-operation discards all in-flight instructions at the next edge. No partial write occurs after that edge.
- Back-to-back stalls are permitted. Each stall cycle inserts one bubble, and `instrD` is re-evaluated every cycle.

## Configuration
- `PIPE_CONTROL_FWD_EN` defined: forwarding logic as above. Only load-use stalls.
- Undefined:
  - `fad` and `fbd` are tied to `00`.
  - `stall` asserts on any RAW hazard: the rs or rt of the ID instruction (nonzero) matches the destination of a register-writing instruction in EX or MEM.
  - WB hazards are covered by the write-first register file.

## Test plan
- Reset: hold `rst` 1 for 2 cycles with `instrD`=add → all outputs 0, no regWrite for 3 cycles after release until the first instruction reaches WB.
- Decode pipeline: `instrD`=lw $8,4($0) for 1 cycle, then nops →
  - cycle+1: aluSrcB=1, aluControl=`010`, regDst=0.
  - cycle+3: regWrite=1, mem2Reg=1.
- Forwarding: add $3,$1,$2 followed by sub $4,$3,$3 → with sub in EX, fad=`10` and fbd=`10`. With an intervening nop, both are `01`. With `PIPE_CONTROL_FWD_EN` undefined, stall=1 for 2 cycles instead.
- Load-use: lw $5,0($0) followed by add $6,$5,$5 → stall=1 for exactly 1 cycle. The next cycle shows a bubble in EX (aluControl=`000`, regDst=0). The add then gets fad=fbd=`01`.
- Branch: beq in EX with zeroE=1 → pcSrc=1 and flush=1 in that cycle, and the next EX bundle is all-zero. With zeroE=0, pcSrc=0 and flush=0.
- $0 guard: addi $0,$0,5 followed by add $7,$0,$0 → fad=fbd=`00` and stall=0.
